// File: rtl/sprite_pkg.sv
// Shared widths, colour keys and animation state encoding for the sprite
// reader and its animation stepper.
package sprite_pkg;

  localparam int PIX_W  = 16;
  localparam int HCNT_W = 10;
  localparam int ADDR_W = 8;
  localparam int STEP_W = 4;

  localparam logic [PIX_W-1:0] TRANS_KEY = 16'hF81F;
  localparam logic [PIX_W-1:0] BG_COLOR  = 16'h0000;

  typedef enum logic [0:0] {
    S_STOP = 1'b0,
    S_RUN  = 1'b1
  } anim_state_t;

  // Signed raster offset, one bit wider than the counters so that a pixel
  // left of or above the origin shows up as negative instead of wrapping.
  typedef logic signed [HCNT_W:0] offset_t;

  function automatic logic in_span(input offset_t d, input int span);
    return !d[HCNT_W] && (int'(d) < span);
  endfunction

endpackage

// File: rtl/sprite_reader_anim_stepper.sv
// Animation step counter: detects vsync rising edges and advances the sprite
// frame index every FRAMES_PER_STEP display frames while enabled.
module anim_stepper
  import sprite_pkg::*;
#(
  parameter int NUM_STEPS       = 10,
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync,
  output logic              frame_tick,
  output logic [STEP_W-1:0] step
);

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  logic            vsync_d;
  anim_state_t     state;
  logic [FC_W-1:0] frame_cnt;

  assign frame_tick = vsync & ~vsync_d;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_STOP;
      frame_cnt <= '0;
      step      <= '0;
    end else begin
      case (state)
        S_STOP: begin
          frame_cnt <= '0;
          step      <= '0;
          if (enable) state <= S_RUN;
        end
        S_RUN: begin
          // Dropping enable wins over a frame tick in the same cycle.
          if (!enable) begin
            state     <= S_STOP;
            frame_cnt <= '0;
            step      <= '0;
          end else if (frame_tick) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt <= '0;
              step      <= (step == STEP_LAST) ? '0 : step + 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= S_STOP;
      endcase
    end
  end

endmodule

// File: rtl/sprite_reader.sv
// Sprite ROM reader: maps the raster position onto scaled sprite texels and
// emits a two-stage pipelined pixel stream with a transparency key.
module sprite_reader
  import sprite_pkg::*;
#(
  parameter int               SPRITE_W        = 64,
  parameter int               SPRITE_H        = 64,
  parameter int               SCALE_SH        = 1,
  parameter int               NUM_STEPS       = 10,
  parameter int               FRAMES_PER_STEP = 6,
  parameter logic [PIX_W-1:0] TRANS_KEY       = sprite_pkg::TRANS_KEY,
  parameter logic [PIX_W-1:0] BG_COLOR        = sprite_pkg::BG_COLOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [HCNT_W-1:0] h_cnt,
  input  logic [HCNT_W-1:0] v_cnt,
  input  logic              pix_valid,
  input  logic              vsync,
  input  logic [HCNT_W-1:0] org_x,
  input  logic [HCNT_W-1:0] org_y,
  output logic [ADDR_W-1:0] ram_addr_x,
  output logic [ADDR_W-1:0] ram_addr_y,
  output logic [STEP_W-1:0] step,
  input  logic [PIX_W-1:0]  ram_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_out_valid,
  output logic              hit
);

  localparam int WIN_W = SPRITE_W << SCALE_SH;
  localparam int WIN_H = SPRITE_H << SCALE_SH;

  logic              frame_tick;
  logic [HCNT_W-1:0] org_x_l;
  logic [HCNT_W-1:0] org_y_l;
  offset_t           dx;
  offset_t           dy;
  logic              in_win;
  logic              in_win_d;
  logic              pix_valid_d;
  logic              opaque;

  anim_stepper #(
    .NUM_STEPS       (NUM_STEPS),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_anim_stepper (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .vsync      (vsync),
    .frame_tick (frame_tick),
    .step       (step)
  );

  // Origin only moves between frames so a sprite never tears mid-scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      org_x_l <= '0;
      org_y_l <= '0;
    end else if (frame_tick) begin
      org_x_l <= org_x;
      org_y_l <= org_y;
    end
  end

  assign dx = $signed({1'b0, h_cnt}) - $signed({1'b0, org_x_l});
  assign dy = $signed({1'b0, v_cnt}) - $signed({1'b0, org_y_l});

  assign in_win = pix_valid && in_span(dx, WIN_W) && in_span(dy, WIN_H);

  // Stage 1: texel address to the ROM; address holds outside the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr_x  <= '0;
      ram_addr_y  <= '0;
      in_win_d    <= 1'b0;
      pix_valid_d <= 1'b0;
    end else begin
      if (in_win) begin
        ram_addr_x <= ADDR_W'(dx[HCNT_W-1:0] >> SCALE_SH);
        ram_addr_y <= ADDR_W'(dy[HCNT_W-1:0] >> SCALE_SH);
      end
      in_win_d    <= in_win;
      pix_valid_d <= pix_valid;
    end
  end

  // ram_data is a combinational ROM read of the stage-1 address and step.
  assign opaque = in_win_d && (ram_data != TRANS_KEY);

  // Stage 2: keyed pixel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_out       <= BG_COLOR;
      pix_out_valid <= 1'b0;
      hit           <= 1'b0;
    end else begin
      pix_out       <= opaque ? ram_data : BG_COLOR;
      pix_out_valid <= pix_valid_d;
      hit           <= opaque;
    end
  end

endmodule

// File: tb/tb_sprite_reader.sv
// Self-checking bench for sprite_reader: window/address table, raster corner
// sequences, animation stepping and randomized pixels against a reference model.
module tb_sprite_reader;
  import sprite_pkg::*;

  localparam int SW  = 64;
  localparam int SH  = 64;
  localparam int SS  = 1;
  localparam int NS  = 10;
  localparam int FPS = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        pix_valid = 1'b0;
  logic        vsync = 1'b0;
  logic [9:0]  org_x = '0;
  logic [9:0]  org_y = '0;
  logic [7:0]  ram_addr_x;
  logic [7:0]  ram_addr_y;
  logic [3:0]  step;
  logic [15:0] ram_data;
  logic [15:0] pix_out;
  logic        pix_out_valid;
  logic        hit;

  int vectors = 0;
  int miscompares = 0;

  int key_x = 5;
  int key_y = 7;

  // Reference state
  int m_org_x = 0;
  int m_org_y = 0;
  int run_ticks = 0;
  bit running = 1'b0;

  typedef struct {
    logic [15:0] pix;
    logic        valid;
    logic        hit;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int h;
    int v;
    bit valid;
    bit e_hit;
    int e_ax;
    int e_ay;
  } vec_t;
  vec_t tbl[10];

  sprite_reader #(
    .SPRITE_W        (SW),
    .SPRITE_H        (SH),
    .SCALE_SH        (SS),
    .NUM_STEPS       (NS),
    .FRAMES_PER_STEP (FPS),
    .TRANS_KEY       (16'hF81F),
    .BG_COLOR        (16'h0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .pix_valid     (pix_valid),
    .vsync         (vsync),
    .org_x         (org_x),
    .org_y         (org_y),
    .ram_addr_x    (ram_addr_x),
    .ram_addr_y    (ram_addr_y),
    .step          (step),
    .ram_data      (ram_data),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .hit           (hit)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // Sprite ROM: one texel is the transparency key, the rest encode step/y/x.
  function automatic logic [15:0] rom_val(input int x, input int y, input int s,
                                          input int kx, input int ky);
    if (x == kx && y == ky) return 16'hF81F;
    return {4'(s), 6'(y), 6'(x)};
  endfunction

  always_comb ram_data = rom_val(int'(ram_addr_x), int'(ram_addr_y), int'(step), key_x, key_y);

  function automatic int model_step();
    return running ? (run_ticks / FPS) % NS : 0;
  endfunction

  function automatic exp_t model_pix(input int h, input int v, input bit valid);
    exp_t e;
    int dx, dy;
    logic [15:0] d;
    dx = h - m_org_x;
    dy = v - m_org_y;
    e.pix = 16'h0000;
    e.valid = valid;
    e.hit = 1'b0;
    if (valid && dx >= 0 && dx < SW * (1 << SS) && dy >= 0 && dy < SH * (1 << SS)) begin
      d = rom_val(dx / (1 << SS), dy / (1 << SS), model_step(), key_x, key_y);
      if (d != 16'hF81F) begin
        e.hit = 1'b1;
        e.pix = d;
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input int h, input int v, input bit valid,
                              input bit e_hit, input int e_ax, input int e_ay);
    vec_t t;
    t.h = h; t.v = v; t.valid = valid;
    t.e_hit = e_hit; t.e_ax = e_ax; t.e_ay = e_ay;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    vsync = 1'b1;
    tick();
    m_org_x = int'(org_x);
    m_org_y = int'(org_y);
    if (running) run_ticks++;
    vsync = 1'b0;
    tick();
    check("step", 32'(step), 32'(model_step()));
  endtask

  task automatic set_enable(input bit en);
    enable = en;
    tick();
    running = en;
    if (!en) run_ticks = 0;
  endtask

  task automatic stream_start();
    exp_t idle;
    idle.pix = 16'h0000; idle.valid = 1'b0; idle.hit = 1'b0;
    exp_q.delete();
    exp_q.push_back(idle);
  endtask

  task automatic stream_cycle(input int h, input int v, input bit valid);
    exp_t e;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    pix_valid = valid;
    tick();
    e = exp_q.pop_front();
    check("pix_out", 32'(pix_out), 32'(e.pix));
    check("pix_out_valid", 32'(pix_out_valid), 32'(e.valid));
    check("hit", 32'(hit), 32'(e.hit));
    exp_q.push_back(model_pix(h & 1023, v & 1023, valid));
  endtask

  task automatic stream_end();
    stream_cycle(0, 0, 1'b0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_out"}, 32'(pix_out), 32'h0000);
    check({tag, "_pix_out_valid"}, 32'(pix_out_valid), 32'd0);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_step"}, 32'(step), 32'd0);
    check({tag, "_addr_x"}, 32'(ram_addr_x), 32'd0);
    check({tag, "_addr_y"}, 32'(ram_addr_y), 32'd0);
  endtask

  initial begin
    int max_step;
    int ox, oy;
    logic [15:0] exp_pix;

    // Window at (100,50), scale 2: columns 100..227, rows 50..177.
    tbl[0] = mk(101, 53,  1'b1, 1'b1, 0,  1);
    tbl[1] = mk(100, 50,  1'b1, 1'b1, 0,  0);
    tbl[2] = mk(99,  50,  1'b1, 1'b0, 0,  0);
    tbl[3] = mk(227, 177, 1'b1, 1'b1, 63, 63);
    tbl[4] = mk(228, 177, 1'b1, 1'b0, 63, 63);
    tbl[5] = mk(227, 178, 1'b1, 1'b0, 63, 63);
    tbl[6] = mk(110, 64,  1'b1, 1'b0, 5,  7);
    tbl[7] = mk(111, 65,  1'b1, 1'b0, 5,  7);
    tbl[8] = mk(150, 100, 1'b0, 1'b0, 5,  7);
    tbl[9] = mk(150, 100, 1'b1, 1'b1, 25, 25);

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Address/pixel table with step frozen at 0
    org_x = 10'd100;
    org_y = 10'd50;
    frame_pulse();
    for (int i = 0; i < 10; i++) begin
      h_cnt = 10'(tbl[i].h);
      v_cnt = 10'(tbl[i].v);
      pix_valid = tbl[i].valid;
      tick();
      check($sformatf("tbl%0d_addr_x", i), 32'(ram_addr_x), 32'(tbl[i].e_ax));
      check($sformatf("tbl%0d_addr_y", i), 32'(ram_addr_y), 32'(tbl[i].e_ay));
      pix_valid = 1'b0;
      tick();
      exp_pix = tbl[i].e_hit ? rom_val(tbl[i].e_ax, tbl[i].e_ay, 0, key_x, key_y) : 16'h0000;
      check($sformatf("tbl%0d_pix_out", i), 32'(pix_out), 32'(exp_pix));
      check($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].e_hit));
      check($sformatf("tbl%0d_valid", i), 32'(pix_out_valid), 32'(tbl[i].valid));
    end

    // Origin at right edge: sprite clips, does not wrap onto column 0
    org_x = 10'd1000;
    org_y = 10'd10;
    frame_pulse();
    stream_start();
    stream_cycle(1023, 10, 1'b1);
    for (int h = 0; h < 10; h++) stream_cycle(h, 11, 1'b1);
    stream_end();

    // Origin change mid-frame takes effect only at the next vsync rise
    org_x = 10'd100;
    org_y = 10'd50;
    stream_start();
    stream_cycle(101, 53, 1'b1);
    stream_cycle(1010, 12, 1'b1);
    stream_end();
    frame_pulse();
    stream_start();
    stream_cycle(101, 53, 1'b1);
    stream_cycle(1010, 12, 1'b1);
    stream_end();

    // Animation: 60 frames walk step 0..9 and wrap back to 0
    set_enable(1'b1);
    max_step = 0;
    for (int k = 0; k < 60; k++) begin
      frame_pulse();
      if (int'(step) > max_step) max_step = int'(step);
    end
    check("step_max", 32'(max_step), 32'd9);
    check("step_wrap", 32'(step), 32'd0);

    // Randomized pixels around random origins, step changing between frames
    for (int c = 0; c < 4; c++) begin
      org_x = 10'($urandom_range(0, 1023));
      org_y = 10'($urandom_range(0, 479));
      frame_pulse();
      ox = int'(org_x);
      oy = int'(org_y);
      stream_start();
      for (int n = 0; n < 80; n++) begin
        stream_cycle((ox + int'($urandom_range(0, 150)) - 10) & 1023,
                     (oy + int'($urandom_range(0, 150)) - 10) & 1023,
                     $urandom_range(0, 3) != 0);
      end
      stream_end();
    end

    // Asynchronous reset in the middle of an opaque pixel stream
    frame_pulse();
    frame_pulse();
    org_x = 10'd100;
    org_y = 10'd50;
    frame_pulse();
    check("step_before_reset", 32'(step != 4'd0), 32'd1);
    stream_start();
    for (int n = 0; n < 3; n++) stream_cycle(120 + n, 60, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    m_org_x = 0;
    m_org_y = 0;
    run_ticks = 0;
    running = 1'b0;
    exp_q.delete();
    tick();
    running = 1'b1;

    // Enable drop in the same cycle as a frame tick forces step to 0
    for (int k = 0; k < 7; k++) frame_pulse();
    check("step_before_drop", 32'(step), 32'd1);
    enable = 1'b0;
    vsync = 1'b1;
    tick();
    running = 1'b0;
    run_ticks = 0;
    m_org_x = int'(org_x);
    m_org_y = int'(org_y);
    check("step_drop", 32'(step), 32'd0);
    vsync = 1'b0;
    tick();
    check("step_drop_hold", 32'(step), 32'd0);
    for (int k = 0; k < 3; k++) frame_pulse();
    stream_start();
    stream_cycle(101, 53, 1'b1);
    stream_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
